// File: rtl/serial_pattern_tx.sv
// Parallel-to-serial pattern transmitter: shifts a programmable-length pattern
// out MSB-first, repeating it with optional idle gaps between passes.
module serial_pattern_tx #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned LEN_W    = 4,
  parameter int unsigned REP_W    = 4,
  parameter int unsigned GAP_W    = 3,
  parameter logic        IDLE_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic [REP_W-1:0] repeat_n,
  input  logic [GAP_W-1:0] gap,
  input  logic             abort,
  output logic             out_bit,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [GAP_W-1:0] gcnt_q, gcnt_d;
  logic             out_bit_q, out_bit_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [LEN_W-1:0] len_eff;

  assign len_eff = (len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : len;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pat_q       <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      rep_q       <= '0;
      gap_q       <= '0;
      gcnt_q      <= '0;
      out_bit_q   <= IDLE_BIT;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pat_q       <= pat_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      rep_q       <= rep_d;
      gap_q       <= gap_d;
      gcnt_q      <= gcnt_d;
      out_bit_q   <= out_bit_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Next-state logic; outputs are decoded from the next state so they
  // register alongside it and stay a pure function of state.
  always_comb begin
    state_d     = state_q;
    pat_d       = pat_q;
    len_d       = len_q;
    idx_d       = idx_q;
    rep_d       = rep_q;
    gap_d       = gap_q;
    gcnt_d      = gcnt_q;
    out_bit_d   = IDLE_BIT;
    out_valid_d = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start && (len != '0)) begin
          state_d = ST_SHIFT;
          pat_d   = pattern;
          len_d   = len_eff;
          idx_d   = len_eff - LEN_W'(1);
          rep_d   = repeat_n;
          gap_d   = gap;
        end
      end
      ST_SHIFT: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (idx_q != '0) begin
          idx_d = idx_q - LEN_W'(1);
        end else if (rep_q == '0) begin
          state_d = ST_DONE;
        end else if (gap_q == '0) begin
          idx_d = len_q - LEN_W'(1);
          rep_d = rep_q - REP_W'(1);
        end else begin
          state_d = ST_GAP;
          gcnt_d  = gap_q - GAP_W'(1);
          rep_d   = rep_q - REP_W'(1);
        end
      end
      ST_GAP: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (gcnt_q == '0) begin
          state_d = ST_SHIFT;
          idx_d   = len_q - LEN_W'(1);
        end else begin
          gcnt_d = gcnt_q - GAP_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (state_d == ST_SHIFT) begin
      out_valid_d = 1'b1;
      out_bit_d   = |(pat_d & (WIDTH'(1) << idx_d));
    end
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  assign out_bit   = out_bit_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: doc/serial_pattern_tx.md
Name: serial_pattern_tx

Overview:
Parallel-to-serial bit-pattern transmitter. Drives a single-bit serial stream for the team's serial sequence detectors and their test benches. A start strobe loads a pattern of programmable length, which the block shifts out MSB-first. The pattern repeats a programmable number of times, with optional idle gaps between repetitions. Moore FSM; all outputs are a function of registered state only.

Parameters:
WIDTH, 8, maximum pattern length in bits
LEN_W, 4, width of len input (must hold WIDTH)
REP_W, 4, width of repeat count
GAP_W, 3, width of inter-repetition gap count
IDLE_BIT, 1'b0, serial line value when not transmitting a pattern bit

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
start  in  1  request; sampled only in IDLE
pattern  in  WIDTH  bits to send; bit [len-1] is sent first
len  in  LEN_W  bits per repetition; 0 = request ignored; >WIDTH clamped to WIDTH
repeat_n  in  REP_W  extra repetitions (total passes = repeat_n+1)
gap  in  GAP_W  idle cycles inserted between passes
abort  in  1  terminate transfer immediately, no done pulse
out_bit  out  1  serial data
out_valid  out  1  high while out_bit carries a pattern bit
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse after the final bit of the final pass

Behaviour:
- Reset: state=IDLE, out_bit=IDLE_BIT, out_valid=0, busy=0, done=0; internal counters cleared. Reset overrides all other inputs, including mid-transfer.
- States: IDLE, SHIFT, GAP, DONE.
- Latched at start acceptance: pattern, len_eff = min(len,WIDTH), repeat_n, gap. The inputs are don't-care afterwards.
- IDLE: start=1 and len!=0 -> SHIFT with idx=len_eff-1, rep_left=repeat_n.
  - Otherwise stay in IDLE.
  - No output changes in the acceptance cycle.
- SHIFT: out_valid=1, out_bit=pat_q[idx]. Each cycle idx decrements.
  - When idx==0 and rep_left==0 -> DONE.
  - When idx==0, rep_left!=0, gap_q==0 -> SHIFT with idx=len_eff-1 and rep_left-1 (back-to-back, no bubble).
  - When idx==0, rep_left!=0, gap_q!=0 -> GAP with gap_cnt=gap_q-1 and rep_left-1.
- GAP: out_valid=0, out_bit=IDLE_BIT. gap_cnt decrements; at gap_cnt==0 -> SHIFT with idx=len_eff-1.
- DONE: done=1, out_valid=0, out_bit=IDLE_BIT, busy=1. Next state IDLE unconditionally.
- IDLE outputs: out_valid=0, out_bit=IDLE_BIT, busy=0, done=0.
- Latency: first bit appears the cycle after the start-sampling edge.
  - SHIFT+GAP cycles = len_eff*(repeat_n+1) + gap*repeat_n.
  - done follows in the next cycle.
  - Earliest next start is accepted in the IDLE cycle after DONE.
- start while busy: ignored; the transfer is not restarted or queued.
- abort: in SHIFT or GAP, next state is IDLE; no done pulse. Ignored in IDLE and DONE. abort and start together in IDLE: start wins.
- len==1: single bit pattern[0] per pass.
- Counters must not wrap: idx never underflows, and rep_left==0 terminates.

Test Plan:
1. Single pass: WIDTH=8, pattern=8'hB4, len=8, repeat_n=0, gap=0, one-cycle start.
   -> out_valid high for exactly 8 cycles, out_bit=1,0,1,1,0,1,0,0.
   -> done=1 on the 9th cycle, busy=0 on the 10th.
2. Repeat with gap: pattern=8'h06, len=3, repeat_n=2, gap=2.
   -> out_bit/out_valid = 1,1,0 (valid), IDLE_BIT x2 (invalid), 1,1,0, IDLE_BIT x2, 1,1,0.
   -> done on cycle 14.
3. Back-to-back: pattern=8'h01, len=2, repeat_n=1, gap=0.
   -> 4 contiguous valid cycles 0,1,0,1, then done.
4. Boundaries:
   -> start with len=0: busy stays 0, no valid cycles.
   -> start with len=12: behaves as len=8.
   -> len=1, pattern=8'h01: single valid cycle with out_bit=1, then done.
5. Interference, transfer started with pattern=8'hFF, len=8:
   -> start re-pulsed at bit 3 with pattern=8'h00: no effect; remaining bits stay 1.
   -> abort at bit 5: next cycle IDLE, out_valid=0, no done pulse.
6. Reset: rst asserted for 2 cycles mid-GAP or mid-SHIFT.
   -> next cycle all outputs at reset values.
   -> a subsequent start transmits normally from bit len-1.
